dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port Data_Memory between the pipeline MEM stage (core port) and a
//  secondary DMA/debug-loader port. Sits between memory_cycle and Data_Memory. Core has
//  default priority and is stalled when the DMA owns the memory. DMA bursts hold a lock,
//  bounded by starvation and burst limits in both directions.
// PARAMETERS
//  AW         32  address width (byte address, word aligned)
//  DW         32  data width
//  MAX_WAIT   4   DMA wait cycles under core contention before one DMA beat is forced
//  MAX_BURST  8   consecutive contended DMA beats before one core beat is forced
//  STAT_W     16  width of statistics counters (DMEM_ARB_STATS_EN only)
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, asynchronous, active-high
//  core_req      in   1   MEM stage access this cycle (MemWriteM | MemtoRegM)
//  core_we       in   1   core write enable
//  core_addr     in   AW  core address (ALU_ResultM)
//  core_wd       in   DW  core write data
//  core_rd       out  DW  core read data, combinational from mem_rd
//  core_stall    out  1   core_req & ~core_gnt; freezes IF..MEM, bubbles MEM/WB
//  dma_req       in   1   DMA beat request, held until dma_gnt
//  dma_we        in   1   DMA write enable
//  dma_last      in   1   final beat of burst; releases lock when granted
//  dma_addr      in   AW  DMA address
//  dma_wd        in   DW  DMA write data
//  dma_gnt       out  1   DMA beat accepted this cycle (combinational)
//  dma_rd        out  DW  registered DMA read data
//  dma_rvalid    out  1   dma_rd valid; one cycle after a granted DMA read
//  mem_we/mem_addr/mem_wd  out  1/AW/DW  to Data_Memory
//  mem_rd        in   DW  Data_Memory read data (combinational read, sync write)
// BEHAVIOUR
//  - One access per cycle. mem_* are muxed from the granted port.
//  - With no grant: mem_we=0, mem_addr=0, mem_wd=0.
//  - States: S_CORE (no lock), S_DMA (DMA burst lock held).
//  - S_CORE: DMA granted if dma_req & (~core_req | wait_cnt==MAX_WAIT); else core granted
//    if core_req. A granted DMA beat with dma_last=0 moves to S_DMA.
//  - S_DMA: DMA granted if dma_req & (~core_req | burst_cnt<MAX_BURST); else core granted
//    if core_req, and the lock is retained. With dma_req=0 the core may use idle cycles.
//    A granted beat with dma_last=1 returns to S_CORE.
//  - wait_cnt: +1 each cycle dma_req & ~dma_gnt & core_req, saturates at MAX_WAIT,
//    cleared on dma_gnt.
//  - burst_cnt: +1 on dma_gnt & core_req, saturates at MAX_BURST, cleared on a core grant
//    or on entry to S_CORE.
//  - Simultaneous requests in S_CORE with wait_cnt<MAX_WAIT: core wins, core_stall=0.
//  - dma_rd/dma_rvalid: on a DMA read grant, dma_rd<=mem_rd and dma_rvalid<=1 next cycle;
//    otherwise dma_rvalid<=0 and dma_rd holds.
//  - Core latency: 0 cycles (core_rd same cycle, captured by the MEM/WB register).
//  - Reset, asynchronous, any time including mid-burst: state=S_CORE, lock dropped,
//    wait_cnt=burst_cnt=0, dma_rvalid=0, dma_rd=0, stats=0.
//  - While rst is high: core_stall=0, dma_gnt=0, mem_we=0; no write reaches memory.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs stat_core_stall [STAT_W] (cycles with
//    core_stall=1) and stat_dma_beats [STAT_W] (dma_gnt cycles). Both saturate at
//    all-ones and are cleared by rst.
//  DMEM_ARB_STATS_EN undefined: those ports and counters are absent; the rest is identical.
// STRUCTURE
//  dmem_arb_pkg: state encoding (S_CORE, S_DMA), owner encoding (OWN_NONE/CORE/DMA),
//    default MAX_WAIT/MAX_BURST constants.
//  Sub-module dmem_arb_sat_counter (param WIDTH; inc, clr, async rst, saturating) used
//    for wait_cnt, burst_cnt and the stats counters.
// TESTING
//  1. Core-only: core_we=1, addr=0x10, wd=0xDEADBEEF, then read 0x10
//     -> core_stall=0 both cycles; core_rd=0xDEADBEEF.
//  2. DMA-only burst of 3 writes to 0x20..0x28, last on beat 3
//     -> dma_gnt 3 consecutive cycles; state back to S_CORE after beat 3.
//  3. core_req held high with dma_req=1 from S_CORE -> core served 4 cycles;
//     5th cycle dma_gnt=1 and core_stall=1.
//  4. 12-beat DMA burst with core_req held high in S_DMA
//     -> 8 DMA beats, 1 core beat, then the remaining DMA beats.
//  5. DMA read of 0x40 holding 0x12345678 -> dma_rvalid=1 with dma_rd=0x12345678 one
//     cycle after dma_gnt.
//  6. rst pulsed mid-burst after beat 2 -> dma_gnt=0, core_stall=0, mem_we=0 during rst;
//     state S_CORE after release; memory unchanged after reset.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter:
// lock-state encoding, port-owner encoding and default starvation limits.
package dmem_arb_pkg;

   typedef enum logic {
      S_CORE = 1'b0,
      S_DMA  = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   localparam int unsigned DEF_MAX_WAIT  = 4;
   localparam int unsigned DEF_MAX_BURST = 8;

   // Bits needed to hold the values 0..maxVal inclusive.
   function automatic int unsigned cntWidth(input int unsigned maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-high reset.
module dmem_arb_sat_counter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned      WIDTH = 4,
   parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port Data_Memory between the MEM-stage core port and a DMA port.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
`ifdef DMEM_ARB_STATS_EN
   ,
   parameter int unsigned STAT_W    = 16
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wd,
   output logic [DW-1:0] core_rd,
   output logic          core_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic          dma_last,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wd,
   output logic          dma_gnt,
   output logic [DW-1:0] dma_rd,
   output logic          dma_rvalid,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_core_stall,
   output logic [STAT_W-1:0] stat_dma_beats
`endif
);

   localparam int unsigned WAIT_W  = cntWidth(MAX_WAIT);
   localparam int unsigned BURST_W = cntWidth(MAX_BURST);
   localparam logic [WAIT_W-1:0]  WAIT_LIM  = WAIT_W'(MAX_WAIT);
   localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

   arb_state_e        state_q;
   arb_state_e        state_d;
   owner_e            owner;
   logic              core_gnt;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [BURST_W-1:0] burst_cnt;
   logic              wait_inc;
   logic              burst_inc;
   logic              burst_clr;
   logic              dma_rd_gnt;
   logic [DW-1:0]     dma_rd_q;
   logic              dma_rvalid_q;

   // Nobody owns the memory while reset is held, so no write can slip through.
   always_comb begin
      owner   = OWN_NONE;
      state_d = state_q;
      if (!rst) begin
         unique case (state_q)
            S_CORE: begin
               if (dma_req && (!core_req || (wait_cnt == WAIT_LIM))) begin
                  owner = OWN_DMA;
               end else if (core_req) begin
                  owner = OWN_CORE;
               end
               if ((owner == OWN_DMA) && !dma_last) begin
                  state_d = S_DMA;
               end
            end
            S_DMA: begin
               if (dma_req && (!core_req || (burst_cnt < BURST_LIM))) begin
                  owner = OWN_DMA;
               end else if (core_req) begin
                  owner = OWN_CORE;
               end
               if ((owner == OWN_DMA) && dma_last) begin
                  state_d = S_CORE;
               end
            end
            default: state_d = S_CORE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_CORE;
      end else begin
         state_q <= state_d;
      end
   end

   assign core_gnt   = (owner == OWN_CORE);
   assign dma_gnt    = (owner == OWN_DMA);
   assign core_stall = core_req & ~core_gnt & ~rst;
   assign core_rd    = mem_rd;

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      if (core_gnt) begin
         mem_we   = core_we;
         mem_addr = core_addr;
         mem_wd   = core_wd;
      end else if (dma_gnt) begin
         mem_we   = dma_we;
         mem_addr = dma_addr;
         mem_wd   = dma_wd;
      end
   end

   // Burst count restarts whenever the core gets a beat or the lock is released.
   assign wait_inc  = dma_req & ~dma_gnt & core_req;
   assign burst_inc = dma_gnt & core_req;
   assign burst_clr = core_gnt | ((state_q == S_DMA) && (state_d == S_CORE));

   dmem_arb_sat_counter #(
      .WIDTH (WAIT_W),
      .MAX   (WAIT_LIM)
   ) u_wait_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (wait_inc),
      .clr_i   (dma_gnt),
      .count_o (wait_cnt)
   );

   dmem_arb_sat_counter #(
      .WIDTH (BURST_W),
      .MAX   (BURST_LIM)
   ) u_burst_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (burst_inc),
      .clr_i   (burst_clr),
      .count_o (burst_cnt)
   );

   assign dma_rd_gnt = dma_gnt & ~dma_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dma_rd_q     <= '0;
         dma_rvalid_q <= 1'b0;
      end else begin
         dma_rvalid_q <= dma_rd_gnt;
         if (dma_rd_gnt) begin
            dma_rd_q <= mem_rd;
         end
      end
   end

   assign dma_rd     = dma_rd_q;
   assign dma_rvalid = dma_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
   dmem_arb_sat_counter #(
      .WIDTH (STAT_W)
   ) u_stat_stall (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (core_stall),
      .clr_i   (1'b0),
      .count_o (stat_core_stall)
   );

   dmem_arb_sat_counter #(
      .WIDTH (STAT_W)
   ) u_stat_beats (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (dma_gnt),
      .clr_i   (1'b0),
      .count_o (stat_dma_beats)
   );
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed scoreboard bench for dmem_port_arbiter with a behavioural Data_Memory
// (combinational read, synchronous write).
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        coreReq, coreWe, dmaReq, dmaWe, dmaLast;
   logic [31:0] coreAddr, coreWd, dmaAddr, dmaWd;
   logic [31:0] coreRd, dmaRd, memAddr, memWd, memRd;
   logic        coreStall, dmaGnt, dmaRvalid, memWe;

   logic [31:0] memArr [256];
   logic [31:0] refMem [256];

   typedef struct {
      logic        stall;
      logic        gnt;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        chkRd;
      logic [31:0] rd;
      logic        rvalid;
      logic [31:0] dRd;
   } exp_t;

   exp_t        expQ [$];
   exp_t        cur;
   logic [31:0] expDmaRd;
   int          vectors     = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (coreReq),
      .core_we    (coreWe),
      .core_addr  (coreAddr),
      .core_wd    (coreWd),
      .core_rd    (coreRd),
      .core_stall (coreStall),
      .dma_req    (dmaReq),
      .dma_we     (dmaWe),
      .dma_last   (dmaLast),
      .dma_addr   (dmaAddr),
      .dma_wd     (dmaWd),
      .dma_gnt    (dmaGnt),
      .dma_rd     (dmaRd),
      .dma_rvalid (dmaRvalid),
      .mem_we     (memWe),
      .mem_addr   (memAddr),
      .mem_wd     (memWd),
      .mem_rd     (memRd)
   );

   assign memRd = memArr[memAddr[9:2]];

   always @(posedge clk) begin
      if (memWe) memArr[memAddr[9:2]] <= memWd;
   end

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Phase 0 pops the next expectation and checks combinational outputs;
   // phase 1 checks the registered DMA read path after the clock edge.
   task automatic checkOutput(input int phase);
      if (phase == 0) begin
         if (expQ.size() == 0) begin
            checkEq("scoreboard_empty", 32'd1, 32'd0);
            return;
         end
         cur = expQ.pop_front();
         checkEq("core_stall", {31'd0, coreStall}, {31'd0, cur.stall});
         checkEq("dma_gnt", {31'd0, dmaGnt}, {31'd0, cur.gnt});
         checkEq("mem_we", {31'd0, memWe}, {31'd0, cur.we});
         checkEq("mem_addr", memAddr, cur.addr);
         checkEq("mem_wd", memWd, cur.wd);
         if (cur.chkRd) checkEq("core_rd", coreRd, cur.rd);
      end else begin
         checkEq("dma_rvalid", {31'd0, dmaRvalid}, {31'd0, cur.rvalid});
         checkEq("dma_rd", dmaRd, cur.dRd);
      end
   endtask

   // One clock of stimulus; expC/expD are the grants this cycle should produce.
   task automatic applyStimulus(input logic r,
                                input logic cReq, input logic cWe,
                                input logic [31:0] cAddr, input logic [31:0] cWd,
                                input logic dReq, input logic dWe, input logic dLast,
                                input logic [31:0] dAddr, input logic [31:0] dWd,
                                input logic expC, input logic expD);
      exp_t e;
      @(negedge clk);
      rst = r;
      coreReq = cReq; coreWe = cWe; coreAddr = cAddr; coreWd = cWd;
      dmaReq = dReq; dmaWe = dWe; dmaLast = dLast; dmaAddr = dAddr; dmaWd = dWd;
      e.stall = !r && cReq && !expC;
      e.gnt   = !r && expD;
      e.we    = 1'b0; e.addr = 32'h0; e.wd = 32'h0;
      if (!r && expC) begin
         e.we = cWe; e.addr = cAddr; e.wd = cWd;
      end else if (!r && expD) begin
         e.we = dWe; e.addr = dAddr; e.wd = dWd;
      end
      e.chkRd = !r && expC && !cWe;
      e.rd    = refMem[cAddr[9:2]];
      if (r) expDmaRd = 32'h0;
      else if (expD && !dWe) expDmaRd = refMem[dAddr[9:2]];
      e.rvalid = !r && expD && !dWe;
      e.dRd    = expDmaRd;
      expQ.push_back(e);
      #2 checkOutput(0);
      if (e.we) refMem[e.addr[9:2]] = e.wd;
      @(posedge clk);
      #1 checkOutput(1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         memArr[i] = 32'h0;
         refMem[i] = 32'h0;
      end
      expDmaRd = 32'h0;
      rst = 1'b1;
      coreReq = 1'b0; coreWe = 1'b0; coreAddr = 32'h0; coreWd = 32'h0;
      dmaReq = 1'b0; dmaWe = 1'b0; dmaLast = 1'b0; dmaAddr = 32'h0; dmaWd = 32'h0;

      $display("[TB] reset with both ports requesting");
      applyStimulus(1, 1, 1, 32'h10, 32'h11111111, 1, 1, 0, 32'h20, 32'h22222222, 0, 0);

      $display("[TB] core-only write then read");
      applyStimulus(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 1, 0);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);

      $display("[TB] DMA-only three-beat burst");
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h20, 32'hA0, 0, 1);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h24, 32'hA4, 0, 1);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h28, 32'hA8, 0, 1);
      applyStimulus(0, 1, 0, 32'h24, 32'h0, 1, 1, 1, 32'h2C, 32'hAC, 1, 0);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h2C, 32'hAC, 0, 1);

      $display("[TB] DMA starvation limit under core contention");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 1, 32'h50 + 32'(4 * i), 32'h500 + 32'(i),
                       1, 1, 1, 32'h30, 32'hC0DE, 1, 0);
      end
      applyStimulus(0, 1, 1, 32'h60, 32'h5FF, 1, 1, 1, 32'h30, 32'hC0DE, 0, 1);
      applyStimulus(0, 1, 0, 32'h30, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
      applyStimulus(0, 1, 0, 32'h5C, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);

      $display("[TB] twelve-beat burst with core contention");
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h100, 32'hA000, 0, 1);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(0, 1, 0, 32'h30, 32'h0, 1, 1, 0, 32'h100 + 32'(4 * i),
                       32'hA000 + 32'(i), 0, 1);
      end
      applyStimulus(0, 1, 0, 32'h30, 32'h0, 1, 1, 0, 32'h124, 32'hA009, 1, 0);
      for (int i = 9; i <= 11; i++) begin
         applyStimulus(0, 1, 0, 32'h30, 32'h0, 1, 1, (i == 11), 32'h100 + 32'(4 * i),
                       32'hA000 + 32'(i), 0, 1);
      end
      applyStimulus(0, 1, 0, 32'h12C, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
      applyStimulus(0, 1, 0, 32'h120, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);

      $display("[TB] DMA read path");
      applyStimulus(0, 1, 1, 32'h40, 32'h12345678, 0, 0, 0, 32'h0, 32'h0, 1, 0);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h40, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

      $display("[TB] reset in the middle of a burst");
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h200, 32'hB0, 0, 1);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h204, 32'hB4, 0, 1);
      applyStimulus(1, 1, 1, 32'h60, 32'hBAD, 1, 1, 0, 32'h208, 32'hB8, 0, 0);
      applyStimulus(0, 1, 0, 32'h208, 32'h0, 1, 1, 1, 32'h20C, 32'hBC, 1, 0);
      applyStimulus(0, 1, 0, 32'h60, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
      applyStimulus(0, 1, 0, 32'h204, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
